image_add_ctrl: RTL and testbench

Sequencing controller for the two-image pixel adder. On a start pulse it sweeps the shared pixel address across both input BRAMs and absorbs their read latency. It registers the 9-bit sum of each pixel pair and writes that sum to the output BRAM at the address it was read from, then pulses done. It replaces the free-running up/down counter as the owner of all BRAM address and enable lines in the adder datapath.

---
 rtl/image_pkg.sv | 30 +++
 rtl/addr_delay_line.sv | 58 +++++
 rtl/image_add_ctrl.sv | 161 ++++++++++++++++
 tb/tb_image_add_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// -----------------------------------------------------------------------------
// image_pkg
// Shared definitions for the two-image pixel adder controller.
//   state_t        : controller FSM states (2-bit encoding)
//   DEF_*          : default BRAM address width, image depth, pixel width and
//                    input BRAM read latency
//   DEF_SUM_W      : default width of a pixel-pair sum (carry in the MSB)
//   sum_width()    : sum width for an arbitrary pixel width
// -----------------------------------------------------------------------------
package image_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DEPTH  = 64;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_RD_LAT = 1;
   localparam int DEF_SUM_W  = DEF_DATA_W + 1;

   // Unsigned sum of two DATA_W-bit pixels needs one extra bit for the carry.
   function automatic int sum_width(input int data_w);
      return data_w + 1;
   endfunction

endpackage

// File: rtl/addr_delay_line.sv
// -----------------------------------------------------------------------------
// addr_delay_line
// RD_LAT-stage shift register of {valid, addr}. Each read address issued to the
// input BRAMs travels alongside the BRAM pipeline so that it emerges on the
// same cycle as the corresponding read data.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-low reset (all stages invalid)
//   flush      in   synchronous clear of every valid bit
//   in_valid   in   a read is being issued this cycle
//   in_addr    in   address of that read
//   out_valid  out  last stage holds a read whose data is on the BRAM outputs
//   out_addr   out  address held in the last stage
//   any_valid  out  at least one stage holds an in-flight read
// -----------------------------------------------------------------------------
module addr_delay_line
   import image_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic              any_valid
);

   logic [RD_LAT-1:0] valid_reg;
   logic [ADDR_W-1:0] addr_reg [RD_LAT];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_reg <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            addr_reg[i] <= '0;
         end
      end else if (flush) begin
         // Only the valid bits matter; stale addresses are never consumed.
         valid_reg <= '0;
      end else begin
         valid_reg[0] <= in_valid;
         addr_reg[0]  <= in_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            valid_reg[i] <= valid_reg[i-1];
            addr_reg[i]  <= addr_reg[i-1];
         end
      end
   end

   assign out_valid = valid_reg[RD_LAT-1];
   assign out_addr  = addr_reg[RD_LAT-1];
   assign any_valid = |valid_reg;

endmodule

// File: rtl/image_add_ctrl.sv
// -----------------------------------------------------------------------------
// image_add_ctrl
// Sequencing controller for the two-image pixel adder. A start pulse sweeps the
// shared read address across both input BRAMs (up or down), the read latency is
// absorbed by addr_delay_line, and each registered pixel-pair sum is written to
// the output BRAM at the address it was read from. done pulses after the last
// write. All outputs are registered.
// Ports:
//   clk                    in   clock, rising edge
//   reset                  in   asynchronous active-low reset
//   start                  in   one-cycle frame request (honoured only in IDLE)
//   dir                    in   scan direction sampled with start (1 = down)
//   abort                  in   cancel the frame in progress
//   busy                   out  frame in progress
//   done                   out  one-cycle pulse after the last output write
//   in_en                  out  read enable for both input BRAMs
//   in_addr                out  shared input BRAM read address
//   in_dout_1, in_dout_2   in   input BRAM read data
//   out_we                 out  output BRAM write enable
//   out_addr               out  output BRAM write address
//   out_din                out  registered sum in_dout_1 + in_dout_2
// -----------------------------------------------------------------------------
module image_add_ctrl
   import image_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DATA_W = DEF_DATA_W,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              dir,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              in_en,
   output logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_dout_1,
   input  logic [DATA_W-1:0] in_dout_2,
   output logic              out_we,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W:0]   out_din
);

   localparam int SUM_W = sum_width(DATA_W);
   localparam logic [ADDR_W-1:0] ADDR_TOP  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   state_t            state_reg, state_next;
   logic              dir_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic              in_en_reg, busy_reg, done_reg, out_we_reg;
   logic [ADDR_W-1:0] out_addr_reg;
   logic [SUM_W-1:0]  out_din_reg;

   logic              accept, last_issue, flush;
   logic              stage_valid, line_busy;
   logic [ADDR_W-1:0] stage_addr;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      flush      = 1'b0;
      // The counter never wraps: the frame ends when the far edge is issued.
      last_issue = (addr_reg == (dir_reg ? ADDR_ZERO : ADDR_TOP));
      case (state_reg)
         ST_IDLE: begin
            if (start && !abort) begin
               accept     = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               flush      = 1'b1;
               state_next = ST_IDLE;
            end else if (last_issue) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               flush      = 1'b1;
               state_next = ST_IDLE;
            end else if (!line_busy) begin
               // Last read has left the delay line; its write is on the
               // outputs this cycle, so done lands on the following cycle.
               state_next = ST_DONE;
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------ read pipeline
   addr_delay_line #(
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_delay (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_en_reg),
      .in_addr   (addr_reg),
      .out_valid (stage_valid),
      .out_addr  (stage_addr),
      .any_valid (line_busy)
   );

   // ----------------------------------------- counter and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dir_reg      <= 1'b0;
         addr_reg     <= '0;
         in_en_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         out_we_reg   <= 1'b0;
         out_addr_reg <= '0;
         out_din_reg  <= '0;
      end else begin
         // Status outputs are decoded from the next state so they line up
         // with the state they describe.
         busy_reg  <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
         done_reg  <= (state_next == ST_DONE);
         in_en_reg <= (state_next == ST_RUN);

         if (accept) begin
            dir_reg  <= dir;
            addr_reg <= dir ? ADDR_TOP : ADDR_ZERO;
         end else if (state_reg == ST_RUN && !abort && !last_issue) begin
            addr_reg <= dir_reg ? (addr_reg - ADDR_ONE) : (addr_reg + ADDR_ONE);
         end

         out_we_reg <= stage_valid && !flush;
         if (stage_valid && !flush) begin
            out_addr_reg <= stage_addr;
            out_din_reg  <= SUM_W'(in_dout_1) + SUM_W'(in_dout_2);
         end
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign in_en    = in_en_reg;
   assign in_addr  = addr_reg;
   assign out_we   = out_we_reg;
   assign out_addr = out_addr_reg;
   assign out_din  = out_din_reg;

endmodule

// File: tb/tb_image_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_image_add_ctrl
// Two controllers (read latency 1 and 3) share clock and stimulus; each has its
// own input BRAM model. Expected writes, done and busy timing are computed from
// the frame rules: write i goes to scan address i (or DEPTH-1-i) at cycle
// n+RD_LAT+2+i with data img1[a]+img2[a]; done at n+DEPTH+RD_LAT+2.
// -----------------------------------------------------------------------------
module tb_image_add_ctrl;
   import image_pkg::*;

   localparam int AW    = 6;
   localparam int DEPTH = 64;
   localparam int DW    = 8;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic dir   = 1'b0;
   logic abort = 1'b0;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic          busy [2], done [2], in_en [2], out_we [2];
   logic [AW-1:0] in_addr [2], out_addr [2];
   logic [DW-1:0] d1 [2], d2 [2];
   logic [DW:0]   out_din [2];

   logic [DW-1:0] img1 [DEPTH];
   logic [DW-1:0] img2 [DEPTH];

   // Input BRAM models: registered read, extra output stages for latency 3.
   logic [DW-1:0] p1 [2][3];
   logic [DW-1:0] p2 [2][3];
   always @(posedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (in_en[j]) begin
            p1[j][0] <= img1[in_addr[j]];
            p2[j][0] <= img2[in_addr[j]];
         end
         p1[j][1] <= p1[j][0];
         p2[j][1] <= p2[j][0];
         p1[j][2] <= p1[j][1];
         p2[j][2] <= p2[j][1];
      end
   end
   assign d1[0] = p1[0][0];
   assign d2[0] = p2[0][0];
   assign d1[1] = p1[1][2];
   assign d2[1] = p2[1][2];

   image_add_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .RD_LAT(1)) dut_l1 (
      .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
      .busy(busy[0]), .done(done[0]), .in_en(in_en[0]), .in_addr(in_addr[0]),
      .in_dout_1(d1[0]), .in_dout_2(d2[0]),
      .out_we(out_we[0]), .out_addr(out_addr[0]), .out_din(out_din[0]));

   image_add_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW), .RD_LAT(3)) dut_l3 (
      .clk(clk), .reset(reset), .start(start), .dir(dir), .abort(abort),
      .busy(busy[1]), .done(done[1]), .in_en(in_en[1]), .in_addr(in_addr[1]),
      .in_dout_1(d1[1]), .in_dout_2(d2[1]),
      .out_we(out_we[1]), .out_addr(out_addr[1]), .out_din(out_din[1]));

   // ------------------------------------------------------------ monitor
   typedef struct {
      int c;
      int a;
      int d;
   } wr_t;

   wr_t wr_q [2][$];
   int  done_q [2][$];
   int  busy_cnt [2];
   int  busy_first [2];
   int  en_cnt [2];

   always @(negedge clk) begin
      for (int j = 0; j < 2; j++) begin
         if (out_we[j]) begin
            wr_t w;
            w.c = cyc;
            w.a = int'(out_addr[j]);
            w.d = int'(out_din[j]);
            wr_q[j].push_back(w);
         end
         if (done[j]) done_q[j].push_back(cyc);
         if (busy[j]) begin
            if (busy_first[j] < 0) busy_first[j] = cyc;
            busy_cnt[j]++;
         end
         if (in_en[j]) en_cnt[j]++;
      end
   end

   task automatic clear_mon();
      for (int j = 0; j < 2; j++) begin
         wr_q[j].delete();
         done_q[j].delete();
         busy_cnt[j]   = 0;
         busy_first[j] = -1;
         en_cnt[j]     = 0;
      end
   endtask

   // ------------------------------------------------------------ checking
   int checks = 0;
   int passes = 0;
   int fails  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs_zero(input string name);
      for (int j = 0; j < 2; j++) begin
         chk($sformatf("%s lat%0d busy", name, j), 32'(busy[j]), 0);
         chk($sformatf("%s lat%0d done", name, j), 32'(done[j]), 0);
         chk($sformatf("%s lat%0d in_en", name, j), 32'(in_en[j]), 0);
         chk($sformatf("%s lat%0d in_addr", name, j), 32'(in_addr[j]), 0);
         chk($sformatf("%s lat%0d out_we", name, j), 32'(out_we[j]), 0);
         chk($sformatf("%s lat%0d out_addr", name, j), 32'(out_addr[j]), 0);
         chk($sformatf("%s lat%0d out_din", name, j), 32'(out_din[j]), 0);
      end
   endtask

   // Compare one frame of one DUT against the reference rules.
   // nexp writes are expected; en_exp/busy_exp count enable and busy cycles.
   task automatic check_frame(input string name, input int j, input int n, input bit d,
                              input int nexp, input int en_exp, input int busy_exp,
                              input bit exp_done);
      int lat = (j == 0) ? 1 : 3;
      chk($sformatf("%s lat%0d write count", name, j), wr_q[j].size(), nexp);
      for (int i = 0; i < nexp && i < wr_q[j].size(); i++) begin
         int a   = d ? DEPTH - 1 - i : i;
         int sum = int'(img1[a]) + int'(img2[a]);
         chk($sformatf("%s lat%0d wr%0d cycle", name, j, i), wr_q[j][i].c, n + lat + 2 + i);
         chk($sformatf("%s lat%0d wr%0d addr", name, j, i), wr_q[j][i].a, a);
         chk($sformatf("%s lat%0d wr%0d data", name, j, i), wr_q[j][i].d, sum);
      end
      chk($sformatf("%s lat%0d done count", name, j), done_q[j].size(), exp_done ? 1 : 0);
      if (exp_done && done_q[j].size() > 0)
         chk($sformatf("%s lat%0d done cycle", name, j), done_q[j][0], n + DEPTH + lat + 2);
      chk($sformatf("%s lat%0d in_en cycles", name, j), en_cnt[j], en_exp);
      chk($sformatf("%s lat%0d busy cycles", name, j), busy_cnt[j], busy_exp);
      chk($sformatf("%s lat%0d busy first", name, j), busy_first[j], n + 1);
      $display("frame %s lat%0d: start n=%0d dir=%0d writes=%0d done_pulses=%0d",
               name, (j == 0) ? 1 : 3, n, d, wr_q[j].size(), done_q[j].size());
   endtask

   // Drives one start at cycle n and runs len cycles. Optional extra start
   // (with flipped dir), abort, and async reset at given offsets (-1 = none).
   task automatic run_frame(input bit d, input int extra_start_at, input int abort_at,
                            input int rst_at, input int len, output int n);
      @(negedge clk);
      clear_mon();
      n     = cyc;
      start = 1'b1;
      dir   = d;
      for (int r = 1; r < len; r++) begin
         @(negedge clk);
         start = (r == extra_start_at);
         dir   = ~d;
         abort = (r == abort_at);
         if (r == rst_at + 2) reset = 1'b1;
         if (r == rst_at) begin
            #2;
            reset = 1'b0;
            #1;
            chk_outputs_zero("async reset");
         end
      end
      #1;
   endtask

   task automatic rand_images();
      for (int i = 0; i < DEPTH; i++) begin
         img1[i] = DW'($urandom_range(0, 255));
         img2[i] = DW'($urandom_range(0, 255));
      end
   endtask

   // ------------------------------------------------------------ sequence
   initial begin
      int n;
      bit d;
      clear_mon();
      for (int i = 0; i < DEPTH; i++) begin
         img1[i] = '0;
         img2[i] = '0;
      end

      // Reset, then idle.
      repeat (3) @(negedge clk);
      reset = 1'b1;
      clear_mon();
      repeat (10) @(negedge clk);
      #1;
      chk_outputs_zero("idle after reset");
      chk("idle lat1 in_en cycles", en_cnt[0], 0);
      chk("idle lat3 in_en cycles", en_cnt[1], 0);

      // Up scan, img1[i]=i, img2[i]=2i.
      for (int i = 0; i < DEPTH; i++) begin
         img1[i] = DW'(i);
         img2[i] = DW'(2 * i);
      end
      run_frame(1'b0, -1, -1, -1, 72, n);
      for (int j = 0; j < 2; j++) check_frame("up ramp", j, n, 1'b0, DEPTH, DEPTH, DEPTH + ((j == 0) ? 1 : 3) + 1, 1'b1);

      // Down scan, saturated pixels: sum must carry to 510.
      for (int i = 0; i < DEPTH; i++) begin
         img1[i] = 8'hFF;
         img2[i] = 8'hFF;
      end
      run_frame(1'b1, -1, -1, -1, 72, n);
      for (int j = 0; j < 2; j++) check_frame("down 255", j, n, 1'b1, DEPTH, DEPTH, DEPTH + ((j == 0) ? 1 : 3) + 1, 1'b1);

      // Random images, random direction, ignored start mid-frame.
      rand_images();
      d = 1'($urandom_range(0, 1));
      run_frame(d, 5, -1, -1, 72, n);
      for (int j = 0; j < 2; j++) check_frame("mid start", j, n, d, DEPTH, DEPTH, DEPTH + ((j == 0) ? 1 : 3) + 1, 1'b1);

      // Abort at n+10: writes stop after n+10, no done.
      rand_images();
      d = 1'($urandom_range(0, 1));
      run_frame(d, -1, 10, -1, 12, n);
      for (int j = 0; j < 2; j++) check_frame("abort", j, n, d, 9 - ((j == 0) ? 1 : 3), 10, 10, 1'b0);

      // Restart right after the abort must run a clean frame.
      d = 1'($urandom_range(0, 1));
      run_frame(d, -1, -1, -1, 72, n);
      for (int j = 0; j < 2; j++) check_frame("restart", j, n, d, DEPTH, DEPTH, DEPTH + ((j == 0) ? 1 : 3) + 1, 1'b1);

      // start and abort together in IDLE: nothing happens.
      @(negedge clk);
      clear_mon();
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (6) @(negedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         chk($sformatf("start+abort lat%0d in_en cycles", j), en_cnt[j], 0);
         chk($sformatf("start+abort lat%0d busy cycles", j), busy_cnt[j], 0);
         chk($sformatf("start+abort lat%0d writes", j), wr_q[j].size(), 0);
      end

      // Async reset at n+20: writes up to n+20 only, nothing afterwards.
      rand_images();
      d = 1'($urandom_range(0, 1));
      run_frame(d, -1, -1, 20, 40, n);
      for (int j = 0; j < 2; j++) check_frame("reset", j, n, d, 19 - ((j == 0) ? 1 : 3), 20, 20, 1'b0);

      // Final clean random frame after the reset.
      rand_images();
      d = 1'($urandom_range(0, 1));
      run_frame(d, -1, -1, -1, 72, n);
      for (int j = 0; j < 2; j++) check_frame("post reset", j, n, d, DEPTH, DEPTH, DEPTH + ((j == 0) ? 1 : 3) + 1, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
